i2c_arbiter: RTL
================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 50_000, cycles allowed from enable pulse to transaction completion.
REQ-002 The block SHALL have port i_Clk, input, 1 bit: single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_Req, input, 3 bits: per-requester transaction request; the requester holds it high until its o_Done or o_Error bit pulses.
REQ-005 The block SHALL have port i_RW, input, 3 bits: per-requester direction, 1 = read, 0 = write.
REQ-006 The block SHALL have port i_Reg_Addr, input, 24 bits: requester n register address in bits [8n+7:8n].
REQ-007 The block SHALL have port i_Write_Data, input, 24 bits: requester n write byte in bits [8n+7:8n].
REQ-008 The block SHALL have port o_Grant, output, 3 bits: one-hot owner of the I2C master; all zeros when no requester owns it.
REQ-009 The block SHALL have port o_Done, output, 3 bits: one-cycle success pulse to the owning requester.
REQ-010 The block SHALL have port o_Error, output, 3 bits: one-cycle timeout pulse to the owning requester.
REQ-011 The block SHALL have port o_Read_Data, output, 8 bits: last byte read, valid with o_Done of a read.
REQ-012 The block SHALL have port o_Busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port o_I2C_Enable, output, 1 bit: start pulse to the i2c_master.
REQ-014 The block SHALL have ports o_I2C_RW (1 bit), o_I2C_Reg_Addr (8 bits) and o_I2C_Write_Data (8 bits), all outputs: transaction fields latched from the winning requester.
REQ-015 The block SHALL have ports i_I2C_Read_Data (8 bits), i_I2C_Data_Valid (1 bit) and i_I2C_Ready (1 bit), all inputs: i2c_master status.

Function
REQ-016 The block SHALL implement the states IDLE, ISSUE, WAIT_START, WAIT_DONE and COOLDOWN.
REQ-017 In IDLE, when any i_Req bit is set and i_I2C_Ready=1, the block SHALL grant round-robin, searching from (last_grant+1) mod 3.
REQ-018 On a grant, the block SHALL latch the winner's RW, address and data fields, set o_Grant one-hot, and go to ISSUE.
REQ-019 If i_I2C_Ready=0 in IDLE, the block SHALL issue no grant.
REQ-020 In ISSUE, the block SHALL hold o_I2C_Enable=1 for exactly one cycle, clear the timeout counter, and go to WAIT_START.
REQ-021 In WAIT_START, the block SHALL go to WAIT_DONE on the first cycle i_I2C_Ready=0.
REQ-022 In WAIT_DONE, when i_I2C_Data_Valid=1 and the latched RW=1, the block SHALL load o_Read_Data from i_I2C_Read_Data.
REQ-023 In WAIT_DONE, when i_I2C_Ready returns to 1, the block SHALL pulse the owner's o_Done bit for one cycle, record the owner as last_grant, clear o_Grant, and go to COOLDOWN.
REQ-024 The timeout counter SHALL increment every cycle in WAIT_START and WAIT_DONE.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse the owner's o_Error bit (o_Done stays 0), record last_grant, clear o_Grant, and go to COOLDOWN.
REQ-026 If timeout and completion occur in the same cycle, completion SHALL win.
REQ-027 COOLDOWN SHALL last exactly one cycle and then return to IDLE, so that a requester dropping i_Req after its done pulse is not re-granted.
REQ-028 i_I2C_Data_Valid outside WAIT_DONE, and during write transactions, SHALL be ignored.
REQ-029 Write transactions SHALL leave o_Read_Data unchanged.
REQ-030 i_Req changes while a requester is not granted SHALL have no effect on the current transaction.
REQ-031 The latched fields SHALL be held stable from the grant until COOLDOWN.
REQ-032 At most one bit of o_Grant, o_Done and o_Error, taken together, SHALL be set in any cycle.
REQ-033 The timeout counter SHALL be 32 bits wide and SHALL saturate rather than wrap.

Reset
REQ-034 With i_Rst=1 at a clock edge, the block SHALL enter IDLE, with all outputs 0 and the timeout counter 0.
REQ-035 On reset, last_grant SHALL be set to 2, so requester 0 has first priority.
REQ-036 Reset mid-transaction SHALL abort it: no o_Done or o_Error pulse, and o_I2C_Enable=0 from the next cycle.

Verification
REQ-037 Single read: i_Req=3'b010, i_RW[1]=1, address 8'h1A; model returns 8'h5C -> one Enable pulse with o_I2C_Reg_Addr=8'h1A, then o_Done=3'b010 and o_Read_Data=8'h5C.
REQ-038 Contention: i_Req=3'b111 held, each requester re-requesting after its done -> grant order 0, 1, 2, 0, with no back-to-back re-grant of the same requester.
REQ-039 Write: requester 2 writes 8'h0C to address 8'h3D -> o_I2C_RW=0 and o_I2C_Write_Data=8'h0C; o_Read_Data unchanged.
REQ-040 Timeout: TIMEOUT_CYCLES=100 and the model never drops i_I2C_Ready -> o_Error pulses 100 cycles after ISSUE, o_Done stays 0, and the next requester is then granted.
REQ-041 Reset in WAIT_DONE -> all outputs 0 on the next cycle; after release, i_Req=3'b001 is granted normally.
REQ-042 i_I2C_Ready=0 at a request -> no grant until Ready=1; stray i_I2C_Data_Valid during a write -> o_Read_Data unchanged.

Source files
------------

// File: rtl/i2c_arbiter_if.sv
// Signal bundle between three requesters, the arbiter and a single i2c_master.
// slave: the arbiter's view; master: the requesters plus the i2c_master side.
interface i2c_arbiter_if;
    logic [2:0]  i_Req;
    logic [2:0]  i_RW;
    logic [23:0] i_Reg_Addr;
    logic [23:0] i_Write_Data;
    logic [2:0]  o_Grant;
    logic [2:0]  o_Done;
    logic [2:0]  o_Error;
    logic [7:0]  o_Read_Data;
    logic        o_Busy;
    logic        o_I2C_Enable;
    logic        o_I2C_RW;
    logic [7:0]  o_I2C_Reg_Addr;
    logic [7:0]  o_I2C_Write_Data;
    logic [7:0]  i_I2C_Read_Data;
    logic        i_I2C_Data_Valid;
    logic        i_I2C_Ready;

    modport slave (
        input  i_Req, i_RW, i_Reg_Addr, i_Write_Data,
        input  i_I2C_Read_Data, i_I2C_Data_Valid, i_I2C_Ready,
        output o_Grant, o_Done, o_Error, o_Read_Data, o_Busy,
        output o_I2C_Enable, o_I2C_RW, o_I2C_Reg_Addr, o_I2C_Write_Data
    );

    modport master (
        output i_Req, i_RW, i_Reg_Addr, i_Write_Data,
        output i_I2C_Read_Data, i_I2C_Data_Valid, i_I2C_Ready,
        input  o_Grant, o_Done, o_Error, o_Read_Data, o_Busy,
        input  o_I2C_Enable, o_I2C_RW, o_I2C_Reg_Addr, o_I2C_Write_Data
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master among three requesters, with a
// per-transaction timeout and a one-cycle cooldown between owners.
module i2c_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
    input logic           i_Clk,
    input logic           i_Rst,
    i2c_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitDone,
        StCooldown
    } state_e;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  owner_q, owner_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  done_q, done_d;
    logic [2:0]  error_q, error_d;
    logic [7:0]  read_data_q, read_data_d;
    logic        rw_q, rw_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic        timeout, complete, expire;
    logic [1:0]  cand [3];
    logic [1:0]  pick;
    logic        pick_valid;

    // Search order starts just after the previous owner.
    always_comb begin
        case (last_q)
            2'd0: begin cand[0] = 2'd1; cand[1] = 2'd2; cand[2] = 2'd0; end
            2'd1: begin cand[0] = 2'd2; cand[1] = 2'd0; cand[2] = 2'd1; end
            default: begin cand[0] = 2'd0; cand[1] = 2'd1; cand[2] = 2'd2; end
        endcase
        pick       = 2'd0;
        pick_valid = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (bus.i_Req[cand[k]]) begin
                pick       = cand[k];
                pick_valid = 1'b1;
            end
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    assign timeout = (cnt_inc >= TimeoutLast);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        done_d      = '0;
        error_d     = '0;
        read_data_d = read_data_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        complete    = 1'b0;
        expire      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid && bus.i_I2C_Ready) begin
                    owner_d = pick;
                    grant_d = 3'b001 << pick;
                    rw_d    = bus.i_RW[pick];
                    addr_d  = bus.i_Reg_Addr[{pick, 3'b000} +: 8];
                    wdata_d = bus.i_Write_Data[{pick, 3'b000} +: 8];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                cnt_d = cnt_inc;
                if (timeout) begin
                    expire = 1'b1;
                end else if (!bus.i_I2C_Ready) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_inc;
                if (bus.i_I2C_Data_Valid && rw_q) begin
                    read_data_d = bus.i_I2C_Read_Data;
                end
                // Completion beats a simultaneous timeout.
                if (bus.i_I2C_Ready) begin
                    complete = 1'b1;
                end else if (timeout) begin
                    expire = 1'b1;
                end
            end
            StCooldown: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (complete || expire) begin
            grant_d = '0;
            last_d  = owner_q;
            done_d  = complete ? grant_q : 3'b000;
            error_d = complete ? 3'b000 : grant_q;
            state_d = StCooldown;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= StIdle;
            last_q      <= 2'd2;
            owner_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            error_q     <= '0;
            read_data_q <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            error_q     <= error_d;
            read_data_q <= read_data_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.o_Grant          = grant_q;
    assign bus.o_Done           = done_q;
    assign bus.o_Error          = error_q;
    assign bus.o_Read_Data      = read_data_q;
    assign bus.o_Busy           = (state_q != StIdle);
    assign bus.o_I2C_Enable     = (state_q == StIssue);
    assign bus.o_I2C_RW         = rw_q;
    assign bus.o_I2C_Reg_Addr   = addr_q;
    assign bus.o_I2C_Write_Data = wdata_q;

endmodule
